// File: rtl/dmem_wait_ctrl.sv
// Wait-state data memory: DEPTH_WORDS x 32 array with byte strobes, fixed LATENCY, one-cycle ready pulse.
// Optional macro DMEM_ERR_EN adds err_o, flagging out-of-range accesses during the response cycle.
module dmem_wait_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  input  logic        write_enable_i,
  input  logic [3:0]  byte_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
`ifdef DMEM_ERR_EN
  output logic        err_o,
`endif
  output logic [1:0]  dbg_state_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, next_state;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            enter_resp;

  logic            we_q, oor_q;
  logic [3:0]      be_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wd_q;

  logic            eff_we, eff_oor;
  logic [3:0]      eff_be;
  logic [AW-1:0]   eff_idx;
  logic [31:0]     eff_wd;
  logic            req_oor;

  logic [31:0]     mem [DEPTH_WORDS];

  // The word offset inside a word is the lsu's job (byte strobes + lane data).
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[1:0];

  assign req_oor = ({1'b0, addr_i} >= ADDR_LIMIT);

  // Handshake: lsu raises mem_req_i and holds it with stable fields until it
  // sees ready_o; fields are sampled only on the accepting edge in IDLE, and
  // ready_o is a single-cycle pulse in RESP. Requests seen in WAIT/RESP are ignored.
  always_comb begin
    next_state = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            cnt_d      = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) next_state = RESP;
        else             cnt_d = cnt_q - 1'b1;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With LATENCY=1 the commit edge is also the accept edge, so use live inputs then.
  always_comb begin
    eff_we  = we_q;
    eff_be  = be_q;
    eff_idx = idx_q;
    eff_wd  = wd_q;
    eff_oor = oor_q;
    if (state_q == IDLE) begin
      eff_we  = write_enable_i;
      eff_be  = byte_enable_i;
      eff_idx = addr_i[AW+1:2];
      eff_wd  = write_data_i;
      eff_oor = req_oor;
    end
  end

  assign enter_resp = (next_state == RESP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      idx_q       <= '0;
      wd_q        <= '0;
      oor_q       <= 1'b0;
      read_data_o <= '0;
    end else begin
      state_q <= next_state;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q  <= write_enable_i;
        be_q  <= byte_enable_i;
        idx_q <= addr_i[AW+1:2];
        wd_q  <= write_data_i;
        oor_q <= req_oor;
      end
      if (enter_resp && !eff_we) begin
        read_data_o <= eff_oor ? 32'h0 : mem[eff_idx];
      end
    end
  end

  // Array has no reset; a reset aborting an access must not let its write land.
  always_ff @(posedge clk_i) begin
    if (rst_ni && enter_resp && eff_we && !eff_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_be[b]) mem[eff_idx][8*b +: 8] <= eff_wd[8*b +: 8];
      end
    end
  end

  assign ready_o     = (state_q == RESP);
  assign dbg_state_o = state_q;

`ifdef DMEM_ERR_EN
  assign err_o = (state_q == RESP) && oor_q;
`endif

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Self-checking bench for dmem_wait_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized accesses against a word-array reference model.
module tb_dmem_wait_ctrl;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam logic [31:0] LIMIT = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        ready;
  logic        err;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_rd = '0;

  dmem_wait_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mem_req_i      (mem_req),
    .write_enable_i (we),
    .byte_enable_i  (be),
    .addr_i         (addr),
    .write_data_i   (wd),
    .read_data_o    (rd),
    .ready_o        (ready),
`ifdef DMEM_ERR_EN
    .err_o          (err),
`endif
    .dbg_state_o    (dbg_state)
  );

`ifndef DMEM_ERR_EN
  assign err = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one access starting at a negedge; returns at a negedge after the pulse has ended.
  task automatic do_access(input logic a_we, input logic [3:0] a_be, input logic [31:0] a_addr,
                           input logic [31:0] a_wd, output logic [31:0] a_rd,
                           output logic a_err, output int a_lat);
    we = a_we; be = a_be; addr = a_addr; wd = a_wd; mem_req = 1'b1;
    a_lat = -1; a_rd = 'x; a_err = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (ready) begin
        a_lat = k; a_rd = rd; a_err = err;
        break;
      end
    end
    mem_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ready_pulse_width", {31'b0, ready}, 32'h0);
  endtask

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[15];
  logic [31:0] ref_mem[16];

  initial begin
    logic [31:0] got_rd, first_rd, exp;
    logic        got_err;
    int          lat, p1, p2;
    logic [31:0] r_addr, r_wd;
    logic [3:0]  r_be;
    logic        r_we, r_oor;

    tbl[0]  = '{1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 4'h0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 4'h4, 32'h10,   32'h00AA0000, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 32'h10,   32'h0,        32'hDEAABEEF, 1'b0};
    tbl[4]  = '{1'b1, 4'h0, 32'h10,   32'h12121212, 32'hDEAABEEF, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 32'h10,   32'h0,        32'hDEAABEEF, 1'b0};
    tbl[6]  = '{1'b1, 4'hF, 32'h14,   32'h0BADF00D, 32'hDEAABEEF, 1'b0};
    tbl[7]  = '{1'b1, 4'hF, 32'h20,   32'h12345678, 32'hDEAABEEF, 1'b0};
    tbl[8]  = '{1'b0, 4'h0, 32'h1000, 32'h0,        32'h0,        1'b1};
    tbl[9]  = '{1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[10] = '{1'b0, 4'h0, 32'h20,   32'h0,        32'h12345678, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 32'h13,   32'h0,        32'hDEAABEEF, 1'b0};
    tbl[12] = '{1'b1, 4'hF, 32'h1010, 32'h00000000, 32'hDEAABEEF, 1'b1};
    tbl[13] = '{1'b0, 4'h0, 32'h10,   32'h0,        32'hDEAABEEF, 1'b0};
    tbl[14] = '{1'b0, 4'h0, 32'h14,   32'h0,        32'h0BADF00D, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ready", {31'b0, ready}, 32'h0);
    check("reset_rdata", rd, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      do_access(tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wd, got_rd, got_err, lat);
      check($sformatf("tbl%0d_latency", i), lat, LAT);
      check($sformatf("tbl%0d_rdata", i), got_rd, tbl[i].exp_rd);
`ifdef DMEM_ERR_EN
      check($sformatf("tbl%0d_err", i), {31'b0, got_err}, {31'b0, tbl[i].exp_err});
`endif
    end

    // Request held high across two reads
    we = 1'b0; be = 4'h0; addr = 32'h10; wd = '0; mem_req = 1'b1;
    p1 = -1; p2 = -1; first_rd = 32'h0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (ready) begin
        if (p1 < 0) begin
          p1 = k; first_rd = rd;
          check("held_rd1", rd, 32'hDEAABEEF);
          addr = 32'h14;
        end else begin
          p2 = k;
          check("held_rd2", rd, 32'h0BADF00D);
          mem_req = 1'b0;
          break;
        end
      end else if (p1 > 0) begin
        check("held_rdata_hold", rd, first_rd);
      end
    end
    mem_req = 1'b0;
    check("held_pulse1", p1, LAT);
    check("held_pulse2", p2, 2 * LAT + 1);
    @(posedge clk); @(negedge clk);
    check("held_pulse2_width", {31'b0, ready}, 32'h0);

    // Reset while a write is in WAIT: no pulse, write dropped, outputs clear at once
    we = 1'b1; be = 4'hF; addr = 32'h20; wd = 32'hFFFFFFFF; mem_req = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_wait_ready", {31'b0, ready}, 32'h0);
    #2 rst_n = 1'b0; mem_req = 1'b0;
    #1;
    check("async_reset_ready", {31'b0, ready}, 32'h0);
    check("async_reset_rdata", rd, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("in_reset_ready", {31'b0, ready}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_access(1'b0, 4'h0, 32'h20, 32'h0, got_rd, got_err, lat);
    check("post_abort_latency", lat, LAT);
    check("post_abort_rdata", got_rd, 32'h12345678);

    // Reset in the response cycle cuts the pulse short
    we = 1'b0; be = 4'h0; addr = 32'h10; mem_req = 1'b1;
    repeat (LAT) begin @(posedge clk); @(negedge clk); end
    check("resp_before_reset", {31'b0, ready}, 32'h1);
    #2 rst_n = 1'b0; mem_req = 1'b0;
    #1;
    check("reset_in_resp_ready", {31'b0, ready}, 32'h0);
    check("reset_in_resp_rdata", rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    last_rd = 32'h0;

    // Randomized accesses against the reference array (words 0..15 plus out-of-range)
    for (int w = 0; w < 16; w++) begin
      r_wd = $urandom();
      ref_mem[w] = r_wd;
      do_access(1'b1, 4'hF, w * 4, r_wd, got_rd, got_err, lat);
      check("init_latency", lat, LAT);
      check("init_rdata_hold", got_rd, last_rd);
    end
    for (int i = 0; i < 150; i++) begin
      r_we = ($urandom_range(0, 1) == 1);
      r_be = 4'($urandom_range(0, 15));
      r_wd = $urandom();
      if ($urandom_range(0, 7) == 0) r_addr = $urandom_range(32'h1000, 32'hFFFFFFFF);
      else                           r_addr = ($urandom_range(0, 15) * 4) | $urandom_range(0, 3);
      r_oor = (r_addr >= LIMIT);
      if (r_we) begin
        exp = last_rd;
        if (!r_oor)
          for (int b = 0; b < 4; b++)
            if (r_be[b]) ref_mem[r_addr[5:2]][8*b +: 8] = r_wd[8*b +: 8];
      end else begin
        exp = r_oor ? 32'h0 : ref_mem[r_addr[5:2]];
        last_rd = exp;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_access(r_we, r_be, r_addr, r_wd, got_rd, got_err, lat);
      check($sformatf("rand%0d_latency", i), lat, LAT);
      check($sformatf("rand%0d_rdata", i), got_rd, exp);
`ifdef DMEM_ERR_EN
      check($sformatf("rand%0d_err", i), {31'b0, got_err}, {31'b0, r_oor});
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
